// File: rtl/weight_mem_ctrl_mc_if.sv
// Bus bundle for the weight memory controller. The master side (loader or bench)
// drives configuration, data and handshakes; the slave side is the controller.
interface weight_mem_ctrl_mc_if #(
  parameter int WMC_DATA_WIDTH = 8,
  parameter int WMC_ADDR_WIDTH = 9,
  parameter int WMC_CH_WIDTH   = 4
);
  logic [WMC_ADDR_WIDTH-1:0]                WMC_W_Size;
  logic [WMC_ADDR_WIDTH-1:0]                WMC_W_COXRW;
  logic [WMC_CH_WIDTH-1:0]                  WMC_Channels;
  logic [WMC_DATA_WIDTH-1:0]                WMC_Input_Data;
  logic                                     WMC_Input_Valid;
  logic                                     WMC_Start_Loading_Weights;
  logic                                     WMC_Start_Loading_Regs;
  logic                                     WMC_Loading_Weights_Already_Ok;
  logic                                     WMC_Loading_Regs_Already_Ok;
  logic                                     WMC_Loading_Weights_Already;
  logic                                     WMC_Loading_Regs_Already;
  logic [WMC_DATA_WIDTH-1:0]                WMC_Output_Data;
  logic                                     WMC_Muxes_En;
  logic [WMC_ADDR_WIDTH-1:0]                WMC_Muxes_Sel;
  logic [WMC_CH_WIDTH-1:0]                  WMC_Channel;
  logic                                     WMC_All_Channels_Done;
  logic                                     WMC_Busy;
  logic [WMC_DATA_WIDTH+WMC_ADDR_WIDTH-1:0] WMC_Checksum;

  modport slave (
    input  WMC_W_Size, WMC_W_COXRW, WMC_Channels, WMC_Input_Data, WMC_Input_Valid,
           WMC_Start_Loading_Weights, WMC_Start_Loading_Regs,
           WMC_Loading_Weights_Already_Ok, WMC_Loading_Regs_Already_Ok,
    output WMC_Loading_Weights_Already, WMC_Loading_Regs_Already, WMC_Output_Data,
           WMC_Muxes_En, WMC_Muxes_Sel, WMC_Channel, WMC_All_Channels_Done,
           WMC_Busy, WMC_Checksum
  );

  modport master (
    output WMC_W_Size, WMC_W_COXRW, WMC_Channels, WMC_Input_Data, WMC_Input_Valid,
           WMC_Start_Loading_Weights, WMC_Start_Loading_Regs,
           WMC_Loading_Weights_Already_Ok, WMC_Loading_Regs_Already_Ok,
    input  WMC_Loading_Weights_Already, WMC_Loading_Regs_Already, WMC_Output_Data,
           WMC_Muxes_En, WMC_Muxes_Sel, WMC_Channel, WMC_All_Channels_Done,
           WMC_Busy, WMC_Checksum
  );
endinterface

// File: rtl/weight_mem_ctrl_mc.sv
// Weight memory controller: streams weights into a local RAM, then replays one
// channel slice at a time as register-load strobes. WMC_CHECKSUM_EN adds a load checksum.
module weight_mem_ctrl_mc #(
  parameter int WMC_DATA_WIDTH = 8,
  parameter int WMC_MEM_SIZE   = 512,
  parameter int WMC_ADDR_WIDTH = 9,
  parameter int WMC_CH_WIDTH   = 4
) (
  input logic                 WMC_Clk,
  input logic                 WMC_Reset,
  weight_mem_ctrl_mc_if.slave bus
);
  localparam int D = WMC_DATA_WIDTH;
  localparam int A = WMC_ADDR_WIDTH;
  localparam int C = WMC_CH_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_W_DONE, S_READY, S_LOAD_R, S_R_DONE} state_t;
  state_t state_q, state_d;

  logic [D-1:0] mem [WMC_MEM_SIZE];
  logic [D-1:0] rd_q;
  logic [A-1:0] wsize_q, cox_q, wptr_q, rptr_q, k_q, sel_q, rptr_nxt;
  logic [C-1:0] chans_q, ch_q;
  logic         iss_done_q, en_q, done_q;
  logic         start_w_acc, start_r_acc, wr_en, rd_en, w_ok, r_ok, last_ch;

  assign last_ch  = (ch_q == chans_q);
  // rptr is the slice base between loads; wrapping at W_Size gives the mod (W_Size+1)
  assign rptr_nxt = (rptr_q == wsize_q) ? '0 : rptr_q + 1'b1;

  always_ff @(posedge WMC_Clk or posedge WMC_Reset)
    if (WMC_Reset) state_q <= S_IDLE;
    else           state_q <= state_d;

  always_comb begin
    state_d     = state_q;
    start_w_acc = 1'b0;
    start_r_acc = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    w_ok        = 1'b0;
    r_ok        = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.WMC_Start_Loading_Weights) begin
          start_w_acc = 1'b1;
          state_d     = S_LOAD_W;
        end
      S_LOAD_W:
        if (bus.WMC_Input_Valid) begin
          wr_en = 1'b1;
          if (wptr_q == wsize_q) state_d = S_W_DONE;
        end
      S_W_DONE:
        if (bus.WMC_Loading_Weights_Already_Ok) begin
          w_ok    = 1'b1;
          state_d = S_READY;
        end
      S_READY:
        if (bus.WMC_Start_Loading_Weights) begin
          start_w_acc = 1'b1;
          state_d     = S_LOAD_W;
        end else if (bus.WMC_Start_Loading_Regs) begin
          start_r_acc = 1'b1;
          state_d     = S_LOAD_R;
        end
      S_LOAD_R: begin
        rd_en = !iss_done_q;
        // leave only once the last strobe has actually been presented
        if (en_q && sel_q == cox_q) state_d = S_R_DONE;
      end
      S_R_DONE:
        if (bus.WMC_Loading_Regs_Already_Ok) begin
          r_ok    = 1'b1;
          state_d = last_ch ? S_IDLE : S_READY;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge WMC_Clk or posedge WMC_Reset) begin
    if (WMC_Reset) begin
      wsize_q    <= '0;
      cox_q      <= '0;
      chans_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      k_q        <= '0;
      sel_q      <= '0;
      ch_q       <= '0;
      iss_done_q <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_q   <= rd_en;
      sel_q  <= rd_en ? k_q : '0;
      done_q <= r_ok && last_ch;
      if (start_w_acc) begin
        wsize_q <= bus.WMC_W_Size;
        wptr_q  <= '0;
        rptr_q  <= '0;
        ch_q    <= '0;
      end
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (w_ok) begin
        ch_q   <= '0;
        rptr_q <= '0;
      end
      if (start_r_acc) begin
        cox_q      <= bus.WMC_W_COXRW;
        chans_q    <= bus.WMC_Channels;
        k_q        <= '0;
        iss_done_q <= 1'b0;
      end
      if (rd_en) begin
        rptr_q <= rptr_nxt;
        if (k_q == cox_q) iss_done_q <= 1'b1;
        else              k_q        <= k_q + 1'b1;
      end
      if (r_ok) begin
        if (last_ch) begin
          ch_q   <= '0;
          rptr_q <= '0;
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
    end
  end

  // RAM has no reset so weights survive a controller reset
  always_ff @(posedge WMC_Clk) begin
    if (wr_en) mem[wptr_q] <= bus.WMC_Input_Data;
    if (rd_en) rd_q        <= mem[rptr_q];
  end

`ifdef WMC_CHECKSUM_EN
  logic [D+A-1:0] csum_q;
  always_ff @(posedge WMC_Clk or posedge WMC_Reset)
    if (WMC_Reset)        csum_q <= '0;
    else if (start_w_acc) csum_q <= '0;
    else if (wr_en)       csum_q <= csum_q + {{A{1'b0}}, bus.WMC_Input_Data};
  assign bus.WMC_Checksum = csum_q;
`else
  assign bus.WMC_Checksum = '0;
`endif

  assign bus.WMC_Output_Data             = en_q ? rd_q : '0;
  assign bus.WMC_Muxes_En                = en_q;
  assign bus.WMC_Muxes_Sel               = sel_q;
  assign bus.WMC_Channel                 = ch_q;
  assign bus.WMC_All_Channels_Done       = done_q;
  assign bus.WMC_Busy                    = !(state_q == S_IDLE || state_q == S_READY);
  assign bus.WMC_Loading_Weights_Already = (state_q == S_W_DONE);
  assign bus.WMC_Loading_Regs_Already    = (state_q == S_R_DONE);
endmodule

// File: tb/tb_weight_mem_ctrl_mc.sv
// Directed bench for weight_mem_ctrl_mc: weight loads, per-channel register replays
// (including address wrap), input gaps, and reset in the middle of a replay.
module tb_weight_mem_ctrl_mc;
  logic tb_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tb_clk = ~tb_clk;

  weight_mem_ctrl_mc_if wif ();
  weight_mem_ctrl_mc dut (.WMC_Clk(tb_clk), .WMC_Reset(rst), .bus(wif));

  int n_chk  = 0;
  int n_pass = 0;

`ifdef WMC_CHECKSUM_EN
  localparam int EXP_CSUM = 780;
`else
  localparam int EXP_CSUM = 0;
`endif

  typedef struct {
    bit          reload;
    bit          gap;
    int          cox;
    int          chans;
    int          ch;
    bit          last;
    logic [39:0] exp;
  } rv_t;
  rv_t tbl[6];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_en"},    int'(wif.WMC_Muxes_En), 0);
    chk({tag, "_data"},  int'(wif.WMC_Output_Data), 0);
    chk({tag, "_sel"},   int'(wif.WMC_Muxes_Sel), 0);
    chk({tag, "_ch"},    int'(wif.WMC_Channel), 0);
    chk({tag, "_done"},  int'(wif.WMC_All_Channels_Done), 0);
    chk({tag, "_walr"},  int'(wif.WMC_Loading_Weights_Already), 0);
    chk({tag, "_ralr"},  int'(wif.WMC_Loading_Regs_Already), 0);
    chk({tag, "_busy"},  int'(wif.WMC_Busy), 0);
    chk({tag, "_csum"},  int'(wif.WMC_Checksum), 0);
  endtask

  task automatic load_weights(bit gap, bit both_starts);
    int cyc = 0;
    wif.WMC_W_Size                = 9'd11;
    wif.WMC_Start_Loading_Weights = 1'b1;
    wif.WMC_Start_Loading_Regs    = both_starts;
    step();
    wif.WMC_Start_Loading_Weights = 1'b0;
    wif.WMC_Start_Loading_Regs    = 1'b0;
    chk("w_busy", int'(wif.WMC_Busy), 1);
    for (int i = 0; i < 12; i++) begin
      if (gap && i == 6) begin
        wif.WMC_Input_Valid = 1'b0;
        repeat (3) begin step(); cyc++; end
      end
      wif.WMC_Input_Data  = 8'(10 * (i + 1));
      wif.WMC_Input_Valid = 1'b1;
      if (i == 11) chk("w_flag_early", int'(wif.WMC_Loading_Weights_Already), 0);
      step();
      cyc++;
    end
    wif.WMC_Input_Valid = 1'b0;
    wif.WMC_Input_Data  = '0;
    chk("w_flag", int'(wif.WMC_Loading_Weights_Already), 1);
    chk("w_cycles", cyc, gap ? 15 : 12);
    chk("w_csum", int'(wif.WMC_Checksum), EXP_CSUM);
    repeat (3) step();
    chk("w_hold", int'(wif.WMC_Loading_Weights_Already), 1);
    wif.WMC_Loading_Weights_Already_Ok = 1'b1;
    step();
    wif.WMC_Loading_Weights_Already_Ok = 1'b0;
    chk("w_ack", int'(wif.WMC_Loading_Weights_Already), 0);
    chk("w_ready_busy", int'(wif.WMC_Busy), 0);
    chk("w_csum_stable", int'(wif.WMC_Checksum), EXP_CSUM);
  endtask

  task automatic load_regs(rv_t v);
    int  ns    = 0;
    int  first = -1;
    bit  got   = 1'b0;
    wif.WMC_W_COXRW            = 9'(v.cox);
    wif.WMC_Channels           = 4'(v.chans);
    wif.WMC_Start_Loading_Regs = 1'b1;
    step();
    wif.WMC_Start_Loading_Regs = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      step();
      if (wif.WMC_Loading_Regs_Already) got = 1'b1;
      else if (wif.WMC_Muxes_En) begin
        if (first < 0) first = c;
        chk("r_sel", int'(wif.WMC_Muxes_Sel), ns);
        chk("r_data", int'(wif.WMC_Output_Data), (ns < 5) ? int'(v.exp[8*ns +: 8]) : -1);
        chk("r_ch", int'(wif.WMC_Channel), v.ch);
        ns++;
      end else chk("r_data_idle", int'(wif.WMC_Output_Data), 0);
    end
    chk("r_flag", int'(got), 1);
    chk("r_count", ns, v.cox + 1);
    chk("r_first_lat", first, 0);
    step();
    chk("r_hold", int'(wif.WMC_Loading_Regs_Already), 1);
    chk("r_hold_en", int'(wif.WMC_Muxes_En), 0);
    wif.WMC_Loading_Regs_Already_Ok = 1'b1;
    step();
    wif.WMC_Loading_Regs_Already_Ok = 1'b0;
    chk("r_done_pulse", int'(wif.WMC_All_Channels_Done), int'(v.last));
    chk("r_next_ch", int'(wif.WMC_Channel), v.last ? 0 : v.ch + 1);
    chk("r_ack", int'(wif.WMC_Loading_Regs_Already), 0);
    step();
    chk("r_done_clr", int'(wif.WMC_All_Channels_Done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 3, 2, 0, 1'b0, {8'd0,   8'd40,  8'd30,  8'd20,  8'd10}};
    tbl[1] = '{1'b0, 1'b0, 3, 2, 1, 1'b0, {8'd0,   8'd80,  8'd70,  8'd60,  8'd50}};
    tbl[2] = '{1'b0, 1'b0, 3, 2, 2, 1'b1, {8'd0,   8'd120, 8'd110, 8'd100, 8'd90}};
    tbl[3] = '{1'b1, 1'b1, 4, 2, 0, 1'b0, {8'd50,  8'd40,  8'd30,  8'd20,  8'd10}};
    tbl[4] = '{1'b0, 1'b0, 4, 2, 1, 1'b0, {8'd100, 8'd90,  8'd80,  8'd70,  8'd60}};
    tbl[5] = '{1'b0, 1'b0, 4, 2, 2, 1'b1, {8'd30,  8'd20,  8'd10,  8'd120, 8'd110}};

    wif.WMC_W_Size                     = '0;
    wif.WMC_W_COXRW                    = '0;
    wif.WMC_Channels                   = '0;
    wif.WMC_Input_Data                 = '0;
    wif.WMC_Input_Valid                = 1'b0;
    wif.WMC_Start_Loading_Weights      = 1'b0;
    wif.WMC_Start_Loading_Regs         = 1'b0;
    wif.WMC_Loading_Weights_Already_Ok = 1'b0;
    wif.WMC_Loading_Regs_Already_Ok    = 1'b0;

    repeat (2) step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // register start alone in IDLE must not leave IDLE
    wif.WMC_Start_Loading_Regs = 1'b1;
    step();
    wif.WMC_Start_Loading_Regs = 1'b0;
    step();
    chk("idle_regs_ign_busy", int'(wif.WMC_Busy), 0);
    chk("idle_regs_ign_en", int'(wif.WMC_Muxes_En), 0);

    foreach (tbl[i]) begin
      if (tbl[i].reload) load_weights(tbl[i].gap, 1'b0);
      load_regs(tbl[i]);
    end

    // reset during slot 2 of a register replay; both starts high picks weights
    load_weights(1'b0, 1'b1);
    wif.WMC_W_COXRW            = 9'd3;
    wif.WMC_Channels           = 4'd2;
    wif.WMC_Start_Loading_Regs = 1'b1;
    step();
    wif.WMC_Start_Loading_Regs = 1'b0;
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        step();
        if (wif.WMC_Muxes_En && wif.WMC_Muxes_Sel == 9'd2) hit = 1'b1;
      end
      chk("mid_slot2_seen", int'(hit), 1);
    end
    rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    step();
    rst = 1'b0;
    step();
    chk_idle("after_rst");
    load_weights(1'b0, 1'b0);
    load_regs(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/weight_mem_ctrl_mc.md
WEIGHT_MEM_CTRL_MC -- requirements
Module: weight_mem_ctrl_mc

Interface
REQ-001 SHALL have parameters: WMC_DATA_WIDTH, 8, weight word width; WMC_MEM_SIZE, 512, weight memory depth; WMC_ADDR_WIDTH, 9, address/count width; WMC_CH_WIDTH, 4, channel counter width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 WMC_Clk  in  1  clock, all state on rising edge.
REQ-004 WMC_Reset  in  1  asynchronous active-high reset.
REQ-005 WMC_W_Size  in  ADDR  weights to load minus 1.
REQ-006 WMC_W_COXRW  in  ADDR  words per channel slice minus 1.
REQ-007 WMC_Channels  in  CH  channel count minus 1.
REQ-008 WMC_Input_Data  in  DATA  weight word.
REQ-009 WMC_Input_Valid  in  1  Input_Data qualifier.
REQ-010 WMC_Start_Loading_Weights / WMC_Start_Loading_Regs  in  1 each  start pulses.
REQ-011 WMC_Loading_Weights_Already_Ok / WMC_Loading_Regs_Already_Ok  in  1 each  done acknowledges.
REQ-012 WMC_Loading_Weights_Already / WMC_Loading_Regs_Already  out  1 each  done flags.
REQ-013 WMC_Output_Data  out  DATA; WMC_Muxes_En  out  1; WMC_Muxes_Sel  out  ADDR  register-load word, strobe, slot index.
REQ-014 WMC_Channel  out  CH  current channel; WMC_All_Channels_Done  out  1  one-cycle pulse; WMC_Busy  out  1  state not IDLE/READY.
REQ-015 WMC_Checksum  out  DATA+ADDR  load checksum.

Function
REQ-016 States SHALL be IDLE, LOAD_W, W_DONE, READY, LOAD_R, R_DONE.
REQ-017 IDLE: Start_Loading_Weights -> LOAD_W, write pointer 0; if both starts high, weights wins; Start_Loading_Regs alone ignored.
REQ-018 LOAD_W: each edge with Input_Valid=1 writes Input_Data at pointer, pointer+1; Valid=0 cycles write nothing.
REQ-019 Write at pointer==W_Size -> W_DONE; Loading_Weights_Already=1 from next cycle, held until Loading_Weights_Already_Ok=1, then READY with channel 0, base 0.
REQ-020 READY: Start_Loading_Regs -> LOAD_R, slot k=0; Start_Loading_Weights in READY -> LOAD_W (reload).
REQ-021 LOAD_R: synchronous memory read of address (base+k) mod (W_Size+1), k=0..W_COXRW, one per cycle; data appears 1 cycle after address with Muxes_En=1, Muxes_Sel=k.
REQ-022 After strobe for k=W_COXRW -> R_DONE; Loading_Regs_Already=1 held until Loading_Regs_Already_Ok=1.
REQ-023 On Regs Ok: base <- (base+W_COXRW+1) mod (W_Size+1); if Channel==Channels: All_Channels_Done pulse, Channel 0, base 0, IDLE; else Channel+1, READY.
REQ-024 Ok inputs outside matching *_DONE state, Input_Valid outside LOAD_W, starts in other states SHALL be ignored.
REQ-025 Muxes_En=0 and Output_Data=0 whenever no strobe.
REQ-026 Configuration inputs SHALL be sampled at start and held for the operation.

Reset
REQ-027 Reset SHALL force IDLE, pointers/base/Channel/Checksum 0, every output 0, effective immediately, mid-operation included.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro WMC_CHECKSUM_EN defined: Checksum cleared at Start_Loading_Weights, adds each accepted word modulo 2^(DATA+ADDR), stable after W_DONE; undefined: Checksum tied 0, no adder.

Verification
REQ-030 W_Size=11, 12 consecutive valid words 10..120 -> Loading_Weights_Already=1 cycle after 12th write, held until Ok.
REQ-031 Then W_COXRW=3, Channels=2, three reg loads -> ch0 10,20,30,40, ch1 50..80, ch2 90..120, Sel 0..3 each; All_Channels_Done pulses once after third Ok.
REQ-032 Input_Valid low 3 cycles mid-stream -> 12 writes total, Already delayed exactly 3 cycles.
REQ-033 W_Size=11, W_COXRW=4, Channels=2 -> ch2 outputs 110,120,10,20,30 (wrap).
REQ-034 Reset asserted during LOAD_R slot 2 -> Muxes_En, flags, Channel 0 immediately; IDLE; next load proceeds normally.
REQ-035 With WMC_CHECKSUM_EN, load 10..120 -> Checksum=780; without macro -> 0.
